// File: rtl/ex_cond_commit_pkg.sv
// Shared execute-stage constants: flag bit positions, ARM condition codes, default widths.
package ex_cond_commit_pkg;

  localparam int FULLW_DEFAULT = 32;
  localparam int CNTW_DEFAULT  = 16;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/ex_cond_commit_cond_eval.sv
// ARM condition-code evaluator; purely combinational so the branch unit can share it.
module cond_eval
  import ex_cond_commit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_commit.sv
// Execute-stage commit: condition check against committed flags, one-entry writeback
// register, CPSR flag register and annulled-instruction counter.
module ex_cond_commit
  import ex_cond_commit_pkg::*;
#(
  parameter int         FULLW    = FULLW_DEFAULT,
  parameter int         CNTW     = CNTW_DEFAULT,
  parameter logic [3:0] CPSR_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [3:0]       ex_cond,
  input  logic             ex_setflags,
  input  logic             ex_wr_rd,
  input  logic [3:0]       ex_rd,
  input  logic [FULLW-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  input  logic [3:0]       alu_flagsen,
  input  logic             msr_en,
  input  logic [3:0]       msr_flags,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [FULLW-1:0] wb_data,
  output logic [3:0]       wb_rd,
  output logic             wb_we,
  output logic [3:0]       cpsr_flags,
  output logic [CNTW-1:0]  annul_cnt
);

  logic             wb_valid_reg;
  logic [FULLW-1:0] wb_data_reg;
  logic [3:0]       wb_rd_reg;
  logic             wb_we_reg;
  logic [3:0]       cpsr_reg;
  logic [3:0]       cpsr_next;
  logic [3:0]       cpsr_alu;
  logic [CNTW-1:0]  annul_cnt_reg;
  logic             pass;
  logic             acc;
  logic             commit;
  logic             annul;

  cond_eval u_cond_eval (
    .cond  (ex_cond),
    .flags (cpsr_reg),
    .pass  (pass)
  );

  // A flush always drains the slot, so the stage is ready to discard the instruction.
  assign ex_ready = !wb_valid_reg | wb_ready | flush;
  assign acc      = ex_valid & ex_ready & !flush;
  assign commit   = acc & pass;
  assign annul    = acc & !pass;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_flag
      assign cpsr_alu[gi] = alu_flagsen[gi] ? alu_flags[gi] : cpsr_reg[gi];
    end
  endgenerate

  // MSR has priority over an ALU flag update in the same cycle.
  always_comb begin
    cpsr_next = cpsr_reg;
    if (msr_en)
      cpsr_next = msr_flags;
    else if (commit && ex_setflags)
      cpsr_next = cpsr_alu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg  <= 1'b0;
      wb_data_reg   <= '0;
      wb_rd_reg     <= '0;
      wb_we_reg     <= 1'b0;
      cpsr_reg      <= CPSR_RST;
      annul_cnt_reg <= '0;
    end else begin
      cpsr_reg <= cpsr_next;
      if (annul)
        annul_cnt_reg <= annul_cnt_reg + CNTW'(1);
      if (flush) begin
        wb_valid_reg <= 1'b0;
      end else if (commit) begin
        wb_valid_reg <= 1'b1;
        wb_data_reg  <= alu_out;
        wb_rd_reg    <= ex_rd;
        wb_we_reg    <= ex_wr_rd;
      end else if (wb_ready) begin
        wb_valid_reg <= 1'b0;
      end
    end
  end

  assign wb_valid   = wb_valid_reg;
  assign wb_data    = wb_data_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_we      = wb_we_reg;
  assign cpsr_flags = cpsr_reg;
  assign annul_cnt  = annul_cnt_reg;

endmodule

// File: tb/tb_ex_cond_commit.sv
// Self-checking bench for ex_cond_commit: directed scenarios plus randomized traffic
// compared against a behavioural model of the commit stage.
module tb_ex_cond_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_cond;
  logic        ex_setflags;
  logic        ex_wr_rd;
  logic [3:0]  ex_rd;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  alu_flagsen;
  logic        msr_en;
  logic [3:0]  msr_flags;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [3:0]  cpsr_flags;
  logic [15:0] annul_cnt;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit          m_wbv;
  logic [31:0] m_data;
  logic [3:0]  m_rd;
  bit          m_we;
  logic [3:0]  m_cpsr;
  int          m_cnt;

  always #5 clk = ~clk;

  ex_cond_commit #(.FULLW(32), .CNTW(16), .CPSR_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_cond(ex_cond),
    .ex_setflags(ex_setflags), .ex_wr_rd(ex_wr_rd), .ex_rd(ex_rd),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_flagsen(alu_flagsen),
    .msr_en(msr_en), .msr_flags(msr_flags), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .cpsr_flags(cpsr_flags), .annul_cnt(annul_cnt)
  );

  // ARM condition table written in terms of named flags (Z bit0, C bit1, N bit2, V bit3)
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit z, cy, n, v;
    z = f[0]; cy = f[1]; n = f[2]; v = f[3];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_ready();
    return !m_wbv || wb_ready || flush;
  endfunction

  task automatic model_reset();
    m_wbv = 0; m_data = '0; m_rd = '0; m_we = 0; m_cpsr = 4'b0000; m_cnt = 0;
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_cond = 4'hE; ex_setflags = 0; ex_wr_rd = 0; ex_rd = '0;
    alu_out = '0; alu_flags = '0; alu_flagsen = '0; msr_en = 0; msr_flags = '0;
    flush = 0; wb_ready = 1;
  endtask

  task automatic present(input logic [3:0] c, input bit s, input bit we, input logic [3:0] rd,
                         input logic [31:0] d, input logic [3:0] fl, input logic [3:0] en);
    ex_valid = 1; ex_cond = c; ex_setflags = s; ex_wr_rd = we; ex_rd = rd;
    alu_out = d; alu_flags = fl; alu_flagsen = en;
  endtask

  // One clock: the model decides the next state from pre-edge inputs, then the edge happens.
  task automatic step();
    bit acc, p;
    logic [3:0] nc;
    acc = ex_valid && model_ready() && !flush;
    p   = ref_pass(ex_cond, m_cpsr);
    nc  = m_cpsr;
    if (acc && p && ex_setflags)
      for (int i = 0; i < 4; i++) if (alu_flagsen[i]) nc[i] = alu_flags[i];
    if (msr_en) nc = msr_flags;
    @(posedge clk); #1;
    m_cpsr = nc;
    if (acc && !p) m_cnt = (m_cnt + 1) % 65536;
    if (flush) m_wbv = 0;
    else if (acc && p) begin
      m_wbv = 1; m_data = alu_out; m_rd = ex_rd; m_we = ex_wr_rd;
    end else if (wb_ready) m_wbv = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({wb_valid, wb_data, wb_rd, wb_we, cpsr_flags, annul_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_init: got v=%0b d=%h rd=%h we=%0b cpsr=%b cnt=%0d want all 0",
               wb_valid, wb_data, wb_rd, wb_we, cpsr_flags, annul_cnt);
    end
    rst_n = 1;
    present(4'hE, 1, 1, 4'h7, 32'hA5A5A5A5, 4'b0110, 4'b1111);
    step();
    set_idle();
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hA5A5A5A5 || cpsr_flags !== 4'b0110) begin
      n_err++;
      $display("FAIL reset_preload: got v=%0b d=%h cpsr=%b want 1 a5a5a5a5 0110",
               wb_valid, wb_data, cpsr_flags);
    end
    #3 rst_n = 0;
    #1;
    model_reset();
    n_vec++;
    if ({wb_valid, wb_data, wb_rd, wb_we, cpsr_flags, annul_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got v=%0b d=%h rd=%h we=%0b cpsr=%b cnt=%0d want all 0",
               wb_valid, wb_data, wb_rd, wb_we, cpsr_flags, annul_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    $display("reset: async clear checked");
  endtask

  task automatic test_flag_commit();
    present(4'hE, 1, 0, 4'h0, 32'h0, 4'b0001, 4'b0101);
    step();
    n_vec++;
    if (cpsr_flags !== 4'b0001 || wb_we !== 1'b0 || wb_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flag_cmp: got cpsr=%b we=%0b v=%0b want 0001 0 1", cpsr_flags, wb_we, wb_valid);
    end
    present(4'h0, 0, 1, 4'h3, 32'h1234, 4'b0000, 4'b0000);
    step();
    set_idle();
    n_vec++;
    if (wb_data !== 32'h1234 || wb_valid !== 1'b1 || wb_rd !== 4'h3 || wb_we !== 1'b1) begin
      n_err++;
      $display("FAIL flag_beq: got d=%h v=%0b rd=%h we=%0b want 1234 1 3 1", wb_data, wb_valid, wb_rd, wb_we);
    end
    $display("flag_commit: cpsr=%b wb_data=%h", cpsr_flags, wb_data);
  endtask

  task automatic test_annul();
    logic [3:0] f0;
    msr_en = 1; msr_flags = 4'b0001;
    step();
    msr_en = 0;
    f0 = cpsr_flags;
    present(4'h1, 1, 1, 4'h5, 32'h5555, 4'b1110, 4'b1111);
    step();
    set_idle();
    n_vec++;
    if (wb_valid !== 1'b0 || cpsr_flags !== 4'b0001 || annul_cnt !== 16'd1 || f0 !== 4'b0001) begin
      n_err++;
      $display("FAIL annul_ne: got v=%0b cpsr=%b cnt=%0d want 0 0001 1", wb_valid, cpsr_flags, annul_cnt);
    end
    $display("annul: annul_cnt=%0d", annul_cnt);
  endtask

  task automatic test_annul_wrap();
    present(4'hF, 0, 0, 4'h0, 32'h0, 4'b0, 4'b0);
    for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) step();
    n_vec++;
    if (annul_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL annul_full: got cnt=%h want ffff", annul_cnt);
    end
    step();
    set_idle();
    n_vec++;
    if (annul_cnt !== 16'h0000 || annul_cnt !== m_cnt[15:0]) begin
      n_err++;
      $display("FAIL annul_wrap: got cnt=%h want 0000", annul_cnt);
    end
    $display("annul_wrap: annul_cnt=%h", annul_cnt);
  endtask

  task automatic test_backpressure();
    present(4'hE, 0, 1, 4'h9, 32'hDEADBEEF, 4'b0, 4'b0);
    step();
    wb_ready = 0;
    present(4'hE, 0, 1, 4'hA, 32'h11111111, 4'b0, 4'b0);
    #1;
    n_vec++;
    if (ex_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready: got ex_ready=%0b want 0", ex_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_rd !== 4'h9) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%0b d=%h rd=%h want 1 deadbeef 9", k, wb_valid, wb_data, wb_rd);
      end
    end
    wb_ready = 1;
    #1;
    n_vec++;
    if (ex_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got ex_ready=%0b want 1", ex_ready);
    end
    step();
    set_idle();
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h11111111 || wb_rd !== 4'hA) begin
      n_err++;
      $display("FAIL bp_next: got v=%0b d=%h rd=%h want 1 11111111 a", wb_valid, wb_data, wb_rd);
    end
    $display("backpressure: wb_data=%h", wb_data);
  endtask

  task automatic test_flush_msr();
    int c0;
    present(4'hE, 0, 1, 4'h2, 32'hCAFE0000, 4'b0, 4'b0);
    step();
    c0 = int'(annul_cnt);
    wb_ready = 0;
    present(4'hE, 1, 1, 4'h4, 32'h0BAD0BAD, 4'b1111, 4'b1111);
    flush = 1; msr_en = 1; msr_flags = 4'b1010;
    #1;
    n_vec++;
    if (ex_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready: got ex_ready=%0b want 1", ex_ready);
    end
    step();
    set_idle();
    n_vec++;
    if (wb_valid !== 1'b0 || cpsr_flags !== 4'b1010 || int'(annul_cnt) != c0) begin
      n_err++;
      $display("FAIL flush_msr: got v=%0b cpsr=%b cnt=%0d want 0 1010 %0d", wb_valid, cpsr_flags, annul_cnt, c0);
    end
    $display("flush_msr: cpsr=%b", cpsr_flags);
  endtask

  task automatic test_cond_sweep();
    int c0;
    bit exp_p;
    for (int f = 0; f < 16; f++) begin
      set_idle();
      msr_en = 1; msr_flags = 4'(f);
      step();
      msr_en = 0;
      for (int c = 0; c < 16; c++) begin
        c0 = m_cnt;
        exp_p = ref_pass(4'(c), 4'(f));
        present(4'(c), 0, 1, 4'(c), 32'(f * 16 + c), 4'b0, 4'b0);
        step();
        n_vec++;
        if (wb_valid !== exp_p || int'(annul_cnt) != (c0 + (exp_p ? 0 : 1)) % 65536
            || (c == 15 && wb_valid !== 1'b0) || (c == 14 && wb_valid !== 1'b1)) begin
          n_err++;
          $display("FAIL sweep c=%h f=%b: got v=%0b cnt=%0d want v=%0b", c, f, wb_valid, annul_cnt, exp_p);
        end
      end
    end
    set_idle();
    $display("cond_sweep: 256 cond/flag combinations applied");
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      ex_valid    = ($urandom % 4) != 0;
      ex_cond     = 4'($urandom);
      ex_setflags = $urandom % 2;
      ex_wr_rd    = $urandom % 2;
      ex_rd       = 4'($urandom);
      alu_out     = $urandom;
      alu_flags   = 4'($urandom);
      alu_flagsen = 4'($urandom);
      msr_en      = ($urandom % 10) == 0;
      msr_flags   = 4'($urandom);
      flush       = ($urandom % 16) == 0;
      wb_ready    = ($urandom % 3) != 0;
      #1;
      n_vec++;
      if (ex_ready !== model_ready()) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: got %0b want %0b", k, ex_ready, model_ready());
      end
      step();
      n_vec++;
      if (wb_valid !== m_wbv || cpsr_flags !== m_cpsr || int'(annul_cnt) != m_cnt
          || (m_wbv && (wb_data !== m_data || wb_rd !== m_rd || wb_we !== m_we))) begin
        n_err++;
        $display("FAIL rand[%0d]: got v=%0b d=%h rd=%h we=%0b cpsr=%b cnt=%0d want v=%0b d=%h rd=%h we=%0b cpsr=%b cnt=%0d",
                 k, wb_valid, wb_data, wb_rd, wb_we, cpsr_flags, annul_cnt,
                 m_wbv, m_data, m_rd, m_we, m_cpsr, m_cnt);
      end
    end
    set_idle();
    $display("random: 600 cycles applied");
  endtask

  initial begin
    test_reset();
    test_flag_commit();
    test_annul();
    test_annul_wrap();
    test_backpressure();
    test_flush_msr();
    test_cond_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
